// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, default widths,
// requester indices and the ALU opcodes used by the attached datapath.
package alu_arb_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned OPW_DEF   = 4;
  localparam int unsigned FLW_DEF   = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [1:0] idx2onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and response signals around alu_arbiter.
// slave = the arbiter itself, master = requesters plus ALU environment.
interface alu_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned OPW   = OPW_DEF,
  parameter int unsigned FLW   = FLW_DEF
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [OPW-1:0]   req_op0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [OPW-1:0]   req_op1;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_y;
  logic [FLW-1:0]   alu_flags;
  logic [1:0]       rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic [FLW-1:0]   rsp_flags;
  logic             busy;
  logic [15:0]      op_count;

  modport slave (
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
    input  alu_y, alu_flags,
    output req_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_data, rsp_flags, busy, op_count
  );

  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
    output alu_y, alu_flags,
    input  req_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_data, rsp_flags, busy, op_count
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way combinational arbiter. ALU_ARB_RR_EN selects round-robin tie
// breaking; otherwise requester 0 has fixed priority.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_enable,
  output logic [1:0] o_gnt
);

`ifndef ALU_ARB_RR_EN
  logic w_unused_last;
  assign w_unused_last = i_last;
`endif

  // Grant selection; ties resolved by the build-time policy.
  always_comb begin
    o_gnt = 2'b00;
    if (i_enable) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
`ifdef ALU_ARB_RR_EN
        2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
`else
        2'b11:   o_gnt = 2'b01;
`endif
        default: o_gnt = 2'b00;
      endcase
    end else begin
      o_gnt = 2'b00;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: IDLE -> EXEC -> RESP per operation.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned OPW   = OPW_DEF,
  parameter int unsigned FLW   = FLW_DEF
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  state_e           r_state;
  logic             r_gnt;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic [FLW-1:0]   r_rsp_flags;
  logic             r_busy;
  logic [15:0]      r_op_count;

  logic [1:0]       w_gnt;
  logic             w_accept;
  logic             w_win_idx;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [OPW-1:0]   w_sel_op;

  rr_arbiter2 u_arb (
    .i_req    (bus.req_valid),
    .i_last   (r_last_grant),
    .i_enable (r_state == ST_IDLE),
    .o_gnt    (w_gnt)
  );

  assign w_accept  = |(bus.req_valid & w_gnt);
  assign w_win_idx = w_gnt[1];

  // Operand mux for whichever requester currently holds the grant.
  always_comb begin
    w_sel_a  = bus.req_a0;
    w_sel_b  = bus.req_b0;
    w_sel_op = bus.req_op0;
    if (w_win_idx == REQ1) begin
      w_sel_a  = bus.req_a1;
      w_sel_b  = bus.req_b1;
      w_sel_op = bus.req_op1;
    end else begin
      w_sel_a  = bus.req_a0;
      w_sel_b  = bus.req_b0;
      w_sel_op = bus.req_op0;
    end
  end

  // Control FSM with operand, result and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gnt        <= REQ0;
      r_last_grant <= REQ1;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 2'b00;
      r_rsp_data   <= '0;
      r_rsp_flags  <= '0;
      r_busy       <= 1'b0;
      r_op_count   <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rsp_valid <= 2'b00;
          if (w_accept) begin
            r_alu_a      <= w_sel_a;
            r_alu_b      <= w_sel_b;
            r_alu_op     <= w_sel_op;
            r_gnt        <= w_win_idx;
            r_last_grant <= w_win_idx;
            r_busy       <= 1'b1;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // The response pulse is raised here so it is registered during RESP.
          r_rsp_data  <= bus.alu_y;
          r_rsp_flags <= bus.alu_flags;
          r_rsp_valid <= idx2onehot(r_gnt);
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          r_rsp_valid <= 2'b00;
          r_op_count  <= r_op_count + 16'd1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_flags = r_rsp_flags;
  assign bus.busy      = r_busy;
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small behavioural ALU.
// Tie expectations follow ALU_ARB_RR_EN when the bench is built with it.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;
  logic [15:0] alu_res;

  alu_arbiter_if #(.WIDTH(16), .OPW(4), .FLW(4)) bus ();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: flags = {zero, negative, 0, 0}
  always_comb begin
    case (bus.alu_op)
      OP_ADD:  alu_res = bus.alu_a + bus.alu_b;
      OP_SUB:  alu_res = bus.alu_a - bus.alu_b;
      OP_AND:  alu_res = bus.alu_a & bus.alu_b;
      OP_OR:   alu_res = bus.alu_a | bus.alu_b;
      default: alu_res = 16'h0000;
    endcase
  end
  assign bus.alu_y     = alu_res;
  assign bus.alu_flags = {(alu_res == 16'h0000), alu_res[15], 2'b00};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE with valids already driven; returns at the IDLE negedge.
  task automatic do_op(input string tag, input logic [1:0] exp_ready, input logic [15:0] exp_data,
                       input logic [3:0] exp_flags);
    #1;
    check_eq({tag, "_ready"}, bus.req_ready, exp_ready);
    @(negedge clk);
    bus.req_valid = bus.req_valid & ~exp_ready;
    check_eq({tag, "_exec_busy"}, bus.busy, 1'b1);
    check_eq({tag, "_exec_rsp"}, bus.rsp_valid, 2'b00);
    @(negedge clk);
    check_eq({tag, "_rsp_valid"}, bus.rsp_valid, exp_ready);
    check_eq({tag, "_rsp_data"}, bus.rsp_data, exp_data);
    check_eq({tag, "_rsp_flags"}, bus.rsp_flags, exp_flags);
    @(negedge clk);
    check_eq({tag, "_idle_rsp"}, bus.rsp_valid, 2'b00);
    check_eq({tag, "_idle_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    logic [1:0]  tie_first;
    logic [1:0]  tie_second;
    logic [15:0] first_data, second_data;
    logic [3:0]  first_flags, second_flags;

    bus.req_valid = 2'b00;
    bus.req_a0 = 16'd0; bus.req_b0 = 16'd0; bus.req_op0 = 4'd0;
    bus.req_a1 = 16'd0; bus.req_b1 = 16'd0; bus.req_op1 = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);

    // Reset state
    check_eq("rst_ready", bus.req_ready, 2'b00);
    check_eq("rst_alu_a", bus.alu_a, 16'd0);
    check_eq("rst_alu_b", bus.alu_b, 16'd0);
    check_eq("rst_alu_op", bus.alu_op, 4'd0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 2'b00);
    check_eq("rst_rsp_data", bus.rsp_data, 16'd0);
    check_eq("rst_rsp_flags", bus.rsp_flags, 4'd0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_op_count", bus.op_count, 16'd0);

    // Single requester 0: 34 + 10
    bus.req_a0 = 16'd34; bus.req_b0 = 16'd10; bus.req_op0 = OP_ADD;
    bus.req_valid = 2'b01;
    #1;
    check_eq("r0_ready", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;
    check_eq("r0_alu_a", bus.alu_a, 16'd34);
    check_eq("r0_alu_b", bus.alu_b, 16'd10);
    check_eq("r0_busy", bus.busy, 1'b1);
    check_eq("r0_exec_rsp", bus.rsp_valid, 2'b00);
    @(negedge clk);
    check_eq("r0_rsp_valid", bus.rsp_valid, 2'b01);
    check_eq("r0_rsp_data", bus.rsp_data, 16'd44);
    @(negedge clk);
    check_eq("r0_op_count", bus.op_count, 16'd1);
    check_eq("r0_rsp_clear", bus.rsp_valid, 2'b00);
    check_eq("r0_alu_a_hold", bus.alu_a, 16'd34);

    // Reset so last_grant=1, then simultaneous requests
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst2_op_count", bus.op_count, 16'd0);
    bus.req_a0 = 16'd100; bus.req_b0 = 16'd1; bus.req_op0 = OP_ADD;
    bus.req_a1 = 16'd7;   bus.req_b1 = 16'd3; bus.req_op1 = OP_SUB;
    bus.req_valid = 2'b11;
    do_op("tie1_r0", 2'b01, 16'd101, 4'b0000);
    do_op("tie1_r1", 2'b10, 16'd4, 4'b0000);
    check_eq("tie1_op_count", bus.op_count, 16'd2);

    // Requester 0 alone, zero result; leaves last_grant=0
    bus.req_a0 = 16'd5; bus.req_b0 = 16'd5; bus.req_op0 = OP_SUB;
    bus.req_valid = 2'b01;
    do_op("zero", 2'b01, 16'd0, 4'b1000);

    // Second tie: policy-dependent winner
    bus.req_a0 = 16'd9; bus.req_b0 = 16'd6; bus.req_op0 = OP_ADD;
    bus.req_a1 = 16'd3; bus.req_b1 = 16'd5; bus.req_op1 = OP_SUB;
`ifdef ALU_ARB_RR_EN
    tie_first = 2'b10; first_data = 16'hFFFE; first_flags = 4'b0100;
    tie_second = 2'b01; second_data = 16'd15; second_flags = 4'b0000;
`else
    tie_first = 2'b01; first_data = 16'd15; first_flags = 4'b0000;
    tie_second = 2'b10; second_data = 16'hFFFE; second_flags = 4'b0100;
`endif
    bus.req_valid = 2'b11;
    do_op("tie2_first", tie_first, first_data, first_flags);
    do_op("tie2_second", tie_second, second_data, second_flags);
    check_eq("tie2_op_count", bus.op_count, 16'd5);

    // Requester 1 raises and drops valid while requester 0 is in flight
    bus.req_a0 = 16'd12; bus.req_b0 = 16'd10; bus.req_op0 = OP_AND;
    bus.req_a1 = 16'd1;  bus.req_b1 = 16'd1;  bus.req_op1 = OP_ADD;
    bus.req_valid = 2'b01;
    #1;
    check_eq("drop_ready0", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = 2'b10;
    #1;
    check_eq("drop_exec_ready", bus.req_ready, 2'b00);
    @(negedge clk);
    check_eq("drop_rsp_valid", bus.rsp_valid, 2'b01);
    check_eq("drop_rsp_data", bus.rsp_data, 16'd8);
    bus.req_valid = 2'b00;
    @(negedge clk);
    check_eq("drop_idle_ready", bus.req_ready, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("drop_no_rsp", bus.rsp_valid, 2'b00);
      check_eq("drop_no_busy", bus.busy, 1'b0);
    end
    check_eq("drop_op_count", bus.op_count, 16'd6);

    // Reset during EXEC abandons the operation
    bus.req_a0 = 16'd2; bus.req_b0 = 16'd2; bus.req_op0 = OP_ADD;
    bus.req_valid = 2'b01;
    @(negedge clk);
    check_eq("rexec_busy", bus.busy, 1'b1);
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rexec_busy_clr", bus.busy, 1'b0);
    check_eq("rexec_alu_a", bus.alu_a, 16'd0);
    check_eq("rexec_op_count", bus.op_count, 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rexec_no_rsp", bus.rsp_valid, 2'b00);
    end

    // Counter wrap from 0xFFFF
    dut.r_op_count = 16'hFFFF;
    bus.req_a0 = 16'h00F0; bus.req_b0 = 16'h0F00; bus.req_op0 = OP_OR;
    bus.req_valid = 2'b01;
    do_op("wrap", 2'b01, 16'h0FF0, 4'b0000);
    check_eq("wrap_op_count", bus.op_count, 16'h0000);

    // Reset wins over a same-cycle handshake
    bus.req_a0 = 16'h1234; bus.req_b0 = 16'd1; bus.req_op0 = OP_ADD;
    bus.req_valid = 2'b01;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 2'b00;
    check_eq("rhs_busy", bus.busy, 1'b0);
    check_eq("rhs_alu_a", bus.alu_a, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
